// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback path.
package rf_pkg;
   localparam int RF_AW   = 5;
   localparam int RF_DW   = 32;
   localparam int RF_NREQ = 3;
   localparam int RF_NREG = 32;

   localparam int WB_ALU  = 0;
   localparam int WB_LD   = 1;
   localparam int WB_HILO = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request strictly after ptr_i, with wrap.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o
);
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] &&
                i == (int'(ptr_i) + k) % NREQ) begin
               gnt_o[i] = 1'b1;
               idx_o    = PW'(i);
               found    = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among writeback sources,
// with one registered output stage and an in-flight destination mask.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = RF_NREQ,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ*AW-1:0] req_dst,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic             wr_stall,
   output logic             RegWr,
   output logic [AW-1:0]    RW,
   output logic [DW-1:0]    busW,
   output logic [31:0]      inflight_mask,
   output logic [15:0]      grant_cnt
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   last_q, last_d, gnt_idx;
   logic [NREQ-1:0] gnt;
   logic            xfer;
   logic [AW-1:0]   sel_dst;
   logic [DW-1:0]   sel_data;
   logic            regwr_q, regwr_d;
   logic [AW-1:0]   rw_q, rw_d;
   logic [DW-1:0]   busw_q, busw_d;
   logic [15:0]     cnt_q, cnt_d;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req_i (req_valid),
      .ptr_i (last_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign req_ready = (reset_n && !wr_stall) ? gnt : '0;
   assign xfer      = |req_ready;

   always_comb begin
      sel_dst  = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_dst  = sel_dst  | req_dst[i*AW +: AW];
            sel_data = sel_data | req_data[i*DW +: DW];
         end
      end
   end

   // $0 writes are accepted and counted but never reach the file
   always_comb begin
      last_d  = last_q;
      regwr_d = 1'b0;
      rw_d    = rw_q;
      busw_d  = busw_q;
      cnt_d   = cnt_q;
      if (xfer) begin
         last_d = gnt_idx;
         cnt_d  = cnt_q + 16'd1;
         if (sel_dst != '0) begin
            regwr_d = 1'b1;
            rw_d    = sel_dst;
            busw_d  = sel_data;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q  <= PW'(NREQ - 1);
         regwr_q <= 1'b0;
         rw_q    <= '0;
         busw_q  <= '0;
         cnt_q   <= '0;
      end else begin
         last_q  <= last_d;
         regwr_q <= regwr_d;
         rw_q    <= rw_d;
         busw_q  <= busw_d;
         cnt_q   <= cnt_d;
      end
   end

   assign RegWr         = regwr_q;
   assign RW            = rw_q;
   assign busW          = busw_q;
   assign grant_cnt     = cnt_q;
   assign inflight_mask = regwr_q ? (32'd1 << rw_q) : 32'd0;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed checks of rf_wb_arbiter against a
// behavioural model of the grant rule and the write stage.
module tb_rf_wb_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_dst;
   logic [N*DW-1:0] req_data;
   logic            wr_stall;
   logic            RegWr;
   logic [AW-1:0]   RW;
   logic [DW-1:0]   busW;
   logic [31:0]     inflight_mask;
   logic [15:0]     grant_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int            m_last;
   int            m_g;
   bit            m_regwr;
   logic [AW-1:0] m_rw;
   logic [DW-1:0] m_busw;
   int unsigned   m_cnt;

   always #5 clock = ~clock;

   rf_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dst       (req_dst),
      .req_data      (req_data),
      .wr_stall      (wr_stall),
      .RegWr         (RegWr),
      .RW            (RW),
      .busW          (busW),
      .inflight_mask (inflight_mask),
      .grant_cnt     (grant_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] dst_of(input int i);
      return req_dst[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] data_of(input int i);
      return req_data[i*DW +: DW];
   endfunction

   task automatic set_req(input int i, input bit v,
                          input logic [AW-1:0] d,
                          input logic [DW-1:0] x);
      req_valid[i]          = v;
      req_dst[i*AW +: AW]   = d;
      req_data[i*DW +: DW]  = x;
   endtask

   task automatic model_reset();
      m_last  = N - 1;
      m_regwr = 1'b0;
      m_rw    = '0;
      m_busw  = '0;
      m_cnt   = 0;
   endtask

   // next grant: first valid index after the last winner, wrapping
   function automatic int mgrant();
      if (!reset_n || wr_stall) return -1;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_last + k) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic compare(input int g);
      logic [N-1:0] er;
      logic [31:0]  em;
      er = (g >= 0) ? N'(1 << g) : '0;
      em = m_regwr ? (32'd1 << m_rw) : 32'd0;
      chk("req_ready", req_ready, er);
      chk("RegWr", RegWr, m_regwr);
      chk("RW", RW, m_rw);
      chk("busW", busW, m_busw);
      chk("inflight_mask", inflight_mask, em);
      chk("grant_cnt", grant_cnt, m_cnt[15:0]);
   endtask

   task automatic step(input bit rnd);
      @(negedge clock);
      m_g = mgrant();
      compare(m_g);
      @(posedge clock);
      m_regwr = 1'b0;
      if (m_g >= 0) begin
         m_last = m_g;
         m_cnt  = (m_cnt + 1) % 65536;
         if (dst_of(m_g) != '0) begin
            m_regwr = 1'b1;
            m_rw    = dst_of(m_g);
            m_busw  = data_of(m_g);
         end
      end
      #1;
      if (rnd) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || m_g == i)
               set_req(i, $urandom_range(0, 2) != 0,
                       ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom),
                       $urandom);
         end
         wr_stall = ($urandom_range(0, 7) == 0);
      end
   endtask

   initial begin
      int unsigned c0;
      req_valid = '0;
      req_dst   = '0;
      req_data  = '0;
      wr_stall  = 1'b0;
      model_reset();

      set_req(0, 1, 5'd1, 32'hA);
      set_req(1, 1, 5'd2, 32'hB);
      set_req(2, 1, 5'd3, 32'hC);
      repeat (2) step(0);
      chk("rst_ready", req_ready, 0);
      chk("rst_regwr", RegWr, 0);
      chk("rst_cnt", grant_cnt, 0);
      reset_n = 1'b1;
      #1;
      chk("first_grant", req_ready, 3'b001);

      for (int k = 0; k < 6; k++) begin
         step(0);
         chk("rr_regwr", RegWr, 1);
         chk("rr_rw", RW, (k % 3) + 1);
         chk("rr_busw", busW, 32'hA + (k % 3));
         chk("rr_mask", inflight_mask, 32'd1 << ((k % 3) + 1));
      end

      chk("pre_arst_regwr", RegWr, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_regwr", RegWr, 0);
      chk("arst_rw", RW, 0);
      chk("arst_busw", busW, 0);
      chk("arst_mask", inflight_mask, 0);
      chk("arst_cnt", grant_cnt, 0);
      model_reset();
      step(0);
      reset_n = 1'b1;
      step(0);

      set_req(0, 0, '0, '0);
      set_req(2, 0, '0, '0);
      set_req(1, 1, 5'd0, 32'hDEAD);
      #1;
      chk("zero_ready", req_ready, 3'b010);
      c0 = m_cnt;
      step(0);
      chk("zero_regwr", RegWr, 0);
      chk("zero_cnt", grant_cnt, (c0 + 1) % 65536);
      set_req(1, 0, '0, '0);

      set_req(2, 1, 5'd5, 32'h55);
      step(0);
      set_req(2, 0, '0, '0);
      set_req(0, 1, 5'd7, 32'h77);
      wr_stall = 1'b1;
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_wr_done", RegWr, 1);
      chk("stall_wr_rw", RW, 5);
      step(0);
      chk("stall_no_wr", RegWr, 0);
      step(0);
      step(0);
      wr_stall = 1'b0;
      #1;
      chk("stall_resume", req_ready, 3'b001);
      step(0);
      chk("stall_resume_rw", RW, 7);
      set_req(0, 0, '0, '0);

      repeat (3000) step(1);
      wr_stall = 1'b0;

      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      reset_n = 1'b1;
      for (int i = 0; i < N; i++)
         set_req(i, 1, AW'($urandom_range(1, 31)), $urandom);
      repeat (65535) step(0);
      chk("wrap_pre", grant_cnt, 16'hFFFF);
      step(0);
      chk("wrap", grant_cnt, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
